// File: rtl/ysyx_23060124_axil_sram_slave_if.sv
// AXI4-Lite bus bundle between the core-side masters and the SRAM responder.
// Signal names follow the memory slave's AXI port names so waveforms line up
// with the rest of the SoC.
interface ysyx_23060124_axil_sram_slave_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  // Read address / read data channels
  logic [ADDR_W-1:0]   S_AXI_ARADDR;
  logic                S_AXI_ARVALID;
  logic                S_AXI_ARREADY;
  logic [DATA_W-1:0]   S_AXI_RDATA;
  logic [1:0]          S_AXI_RRESP;
  logic                S_AXI_RVALID;
  logic                S_AXI_RREADY;
  // Write address / write data / write response channels
  logic [ADDR_W-1:0]   S_AXI_AWADDR;
  logic                S_AXI_AWVALID;
  logic                S_AXI_AWREADY;
  logic [DATA_W-1:0]   S_AXI_WDATA;
  logic [DATA_W/8-1:0] S_AXI_WSTRB;
  logic                S_AXI_WVALID;
  logic                S_AXI_WREADY;
  logic [1:0]          S_AXI_BRESP;
  logic                S_AXI_BVALID;
  logic                S_AXI_BREADY;

  modport master (
    output S_AXI_ARADDR, S_AXI_ARVALID, S_AXI_RREADY,
    output S_AXI_AWADDR, S_AXI_AWVALID, S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
    output S_AXI_BREADY,
    input  S_AXI_ARREADY, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
    input  S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID
  );

  modport slave (
    input  S_AXI_ARADDR, S_AXI_ARVALID, S_AXI_RREADY,
    input  S_AXI_AWADDR, S_AXI_AWVALID, S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
    input  S_AXI_BREADY,
    output S_AXI_ARREADY, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
    output S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID
  );
endinterface

// File: rtl/ysyx_23060124_axil_sram_slave.sv
// AXI4-Lite SRAM responder: word-addressed array behind independent read and
// write FSMs with configurable response latency.
// Optional feature macro: ysyx_23060124_SRAM_RAND_DELAY_EN -- when defined, an
// 8-bit LFSR adds 0..7 extra cycles to every read and write latency.
//
// Handshake rule (all five channels): a transfer happens on the rising edge
// where VALID and READY are both 1. A raised VALID (RVALID/BVALID here) and its
// payload are held unchanged until that edge; READY never depends
// combinationally on the matching VALID.
module ysyx_23060124_axil_sram_slave #(
  parameter int                ADDR_W     = 32,
  parameter int                DATA_W     = 32,
  parameter int                DEPTH_LOG2 = 12,
  parameter logic [ADDR_W-1:0] BASE_ADDR  = 32'h8000_0000,
  parameter int                RD_LAT     = 1,
  parameter int                WR_LAT     = 1
) (
  input  logic                                  M_AXI_ACLK,
  input  logic                                  ifu_rst,
  ysyx_23060124_axil_sram_slave_if.slave        s_axi,
  output logic [1:0]                            dbg_rd_state_o,
  output logic [1:0]                            dbg_wr_state_o
);

  localparam int         CNT_W       = 16;
  localparam int         DEPTH       = 1 << DEPTH_LOG2;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {R_IDLE = 2'd0, R_WAIT = 2'd1, R_RESP = 2'd2} rd_state_e;
  typedef enum logic [1:0] {W_IDLE = 2'd0, W_WAIT = 2'd1, W_RESP = 2'd2} wr_state_e;

  // Storage: intentionally not reset, contents survive ifu_rst.
  logic [DATA_W-1:0] mem_q [DEPTH];

  // Read channel state
  rd_state_e         rd_state_q, rd_state_d;
  logic [CNT_W-1:0]  rd_cnt_q, rd_cnt_d;
  logic [ADDR_W-1:0] araddr_q, araddr_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [1:0]        rresp_q, rresp_d;

  // Write channel state
  wr_state_e           wr_state_q, wr_state_d;
  logic [CNT_W-1:0]    wr_cnt_q, wr_cnt_d;
  logic [ADDR_W-1:0]   awaddr_q, awaddr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W/8-1:0] wstrb_q, wstrb_d;
  logic                aw_got_q, aw_got_d;
  logic                w_got_q, w_got_d;
  logic [1:0]          bresp_q, bresp_d;

  // Ready strobes kept internal so next-state logic never reads bus outputs
  logic arready, awready, wready;
  logic aw_hs, w_hs;

  // Latency counters count down from (latency - 1) so that a zero count means
  // "the valid/commit edge is the next one".
  logic [CNT_W-1:0] rd_lat_load, wr_lat_load;

`ifdef ysyx_23060124_SRAM_RAND_DELAY_EN
  logic [7:0] lfsr_q, lfsr_d;

  // Fibonacci LFSR, taps for x^8 + x^6 + x^5 + x^4 + 1
  always_comb begin
    lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
  end

  // LFSR advances every cycle, reseeded on reset
  always_ff @(posedge M_AXI_ACLK or negedge ifu_rst) begin
    if (!ifu_rst) lfsr_q <= 8'hA5;
    else          lfsr_q <= lfsr_d;
  end

  assign rd_lat_load = CNT_W'(RD_LAT - 1) + CNT_W'(lfsr_q[2:0]);
  assign wr_lat_load = CNT_W'(WR_LAT - 1) + CNT_W'(lfsr_q[2:0]);
`else
  assign rd_lat_load = CNT_W'(RD_LAT - 1);
  assign wr_lat_load = CNT_W'(WR_LAT - 1);
`endif

  // Address decode: offset from BASE_ADDR; in range when no bits above the
  // array span are set and the address is not below the base.
  logic [ADDR_W-1:0]     rd_off, wr_off;
  logic                  rd_hit, wr_hit;
  logic [DEPTH_LOG2-1:0] rd_idx, wr_idx;
  logic                  wr_commit;

  assign rd_off = araddr_q - BASE_ADDR;
  assign wr_off = awaddr_q - BASE_ADDR;
  assign rd_hit = (araddr_q >= BASE_ADDR) && ((rd_off >> (DEPTH_LOG2 + 2)) == '0);
  assign wr_hit = (awaddr_q >= BASE_ADDR) && ((wr_off >> (DEPTH_LOG2 + 2)) == '0);
  assign rd_idx = rd_off[DEPTH_LOG2+1:2];
  assign wr_idx = wr_off[DEPTH_LOG2+1:2];

  // The commit fires on the same edge that raises BVALID; dropped when out of range
  assign wr_commit = (wr_state_q == W_WAIT) && (wr_cnt_q == '0) && wr_hit;

  // ---------------------------------------------------------------------------
  // Read FSM
  // ---------------------------------------------------------------------------

  // Read state register and datapath registers
  always_ff @(posedge M_AXI_ACLK or negedge ifu_rst) begin
    if (!ifu_rst) begin
      rd_state_q <= R_IDLE;
      rd_cnt_q   <= '0;
      araddr_q   <= '0;
      rdata_q    <= '0;
      rresp_q    <= RESP_OKAY;
    end else begin
      rd_state_q <= rd_state_d;
      rd_cnt_q   <= rd_cnt_d;
      araddr_q   <= araddr_d;
      rdata_q    <= rdata_d;
      rresp_q    <= rresp_d;
    end
  end

  // Read next state: accept AR, count latency, sample array, wait for RREADY
  always_comb begin
    rd_state_d = rd_state_q;
    rd_cnt_d   = rd_cnt_q;
    araddr_d   = araddr_q;
    rdata_d    = rdata_q;
    rresp_d    = rresp_q;
    unique case (rd_state_q)
      R_IDLE: begin
        if (s_axi.S_AXI_ARVALID) begin
          araddr_d   = s_axi.S_AXI_ARADDR;
          rd_cnt_d   = rd_lat_load;
          rd_state_d = R_WAIT;
        end
      end
      R_WAIT: begin
        if (rd_cnt_q == '0) begin
          // Array read sees pre-edge contents, so a same-edge commit is not visible
          rdata_d    = rd_hit ? mem_q[rd_idx] : '0;
          rresp_d    = rd_hit ? RESP_OKAY : RESP_SLVERR;
          rd_state_d = R_RESP;
        end else begin
          rd_cnt_d = rd_cnt_q - CNT_W'(1);
        end
      end
      R_RESP: begin
        if (s_axi.S_AXI_RREADY) rd_state_d = R_IDLE;
      end
      default: rd_state_d = R_IDLE;
    endcase
  end

  // Read channel outputs decoded from state
  always_comb begin
    arready             = (rd_state_q == R_IDLE);
    s_axi.S_AXI_ARREADY = arready;
    s_axi.S_AXI_RVALID  = (rd_state_q == R_RESP);
    s_axi.S_AXI_RDATA   = rdata_q;
    s_axi.S_AXI_RRESP   = rresp_q;
    dbg_rd_state_o      = rd_state_q;
  end

  // ---------------------------------------------------------------------------
  // Write FSM
  // ---------------------------------------------------------------------------

  // Write state register and captured AW/W payload
  always_ff @(posedge M_AXI_ACLK or negedge ifu_rst) begin
    if (!ifu_rst) begin
      wr_state_q <= W_IDLE;
      wr_cnt_q   <= '0;
      awaddr_q   <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      aw_got_q   <= 1'b0;
      w_got_q    <= 1'b0;
      bresp_q    <= RESP_OKAY;
    end else begin
      wr_state_q <= wr_state_d;
      wr_cnt_q   <= wr_cnt_d;
      awaddr_q   <= awaddr_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      aw_got_q   <= aw_got_d;
      w_got_q    <= w_got_d;
      bresp_q    <= bresp_d;
    end
  end

  assign aw_hs = s_axi.S_AXI_AWVALID && awready;
  assign w_hs  = s_axi.S_AXI_WVALID && wready;

  // Write next state: capture AW and W in any order, count latency, respond
  always_comb begin
    wr_state_d = wr_state_q;
    wr_cnt_d   = wr_cnt_q;
    awaddr_d   = awaddr_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    aw_got_d   = aw_got_q;
    w_got_d    = w_got_q;
    bresp_d    = bresp_q;
    unique case (wr_state_q)
      W_IDLE: begin
        if (aw_hs) begin
          awaddr_d = s_axi.S_AXI_AWADDR;
          aw_got_d = 1'b1;
        end
        if (w_hs) begin
          wdata_d = s_axi.S_AXI_WDATA;
          wstrb_d = s_axi.S_AXI_WSTRB;
          w_got_d = 1'b1;
        end
        // Latency starts on the edge that completes the pair
        if (aw_got_d && w_got_d) begin
          wr_cnt_d   = wr_lat_load;
          wr_state_d = W_WAIT;
        end
      end
      W_WAIT: begin
        if (wr_cnt_q == '0) begin
          bresp_d    = wr_hit ? RESP_OKAY : RESP_SLVERR;
          wr_state_d = W_RESP;
        end else begin
          wr_cnt_d = wr_cnt_q - CNT_W'(1);
        end
      end
      W_RESP: begin
        if (s_axi.S_AXI_BREADY) begin
          aw_got_d   = 1'b0;
          w_got_d    = 1'b0;
          wr_state_d = W_IDLE;
        end
      end
      default: wr_state_d = W_IDLE;
    endcase
  end

  // Write channel outputs: each ready stays up until its own beat is held
  always_comb begin
    awready             = (wr_state_q == W_IDLE) && !aw_got_q;
    wready              = (wr_state_q == W_IDLE) && !w_got_q;
    s_axi.S_AXI_AWREADY = awready;
    s_axi.S_AXI_WREADY  = wready;
    s_axi.S_AXI_BVALID  = (wr_state_q == W_RESP);
    s_axi.S_AXI_BRESP   = bresp_q;
    dbg_wr_state_o      = wr_state_q;
  end

  // Byte-lane commit into the array
  always_ff @(posedge M_AXI_ACLK) begin
    if (wr_commit) begin
      for (int i = 0; i < DATA_W / 8; i++) begin
        if (wstrb_q[i]) mem_q[wr_idx][8*i +: 8] <= wdata_q[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_ysyx_23060124_axil_sram_slave.sv
// Directed bench for the AXI4-Lite SRAM responder (default parameters).
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_ysyx_23060124_axil_sram_slave;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;

  logic       clk;
  logic       rst_n;
  logic [1:0] dbg_rd_state;
  logic [1:0] dbg_wr_state;
  int         n_vec;
  int         n_err;

  ysyx_23060124_axil_sram_slave_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  ysyx_23060124_axil_sram_slave dut (
    .M_AXI_ACLK     (clk),
    .ifu_rst        (rst_n),
    .s_axi          (bus),
    .dbg_rd_state_o (dbg_rd_state),
    .dbg_wr_state_o (dbg_wr_state)
  );

  // Clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Driver: present AW and W together; returns after the capture edge
  task automatic drive_aw_w(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    bus.S_AXI_AWADDR  = a;
    bus.S_AXI_AWVALID = 1'b1;
    bus.S_AXI_WDATA   = d;
    bus.S_AXI_WSTRB   = s;
    bus.S_AXI_WVALID  = 1'b1;
    tick();
    bus.S_AXI_AWVALID = 1'b0;
    bus.S_AXI_WVALID  = 1'b0;
  endtask

  // Driver: wait (bounded) for BVALID, report edges waited, then accept B
  task automatic wait_b(output logic [1:0] resp, output int lat);
    lat = 0;
    while (!bus.S_AXI_BVALID && lat < 50) begin
      tick();
      lat++;
    end
    resp = bus.S_AXI_BRESP;
    bus.S_AXI_BREADY = 1'b1;
    tick();
    bus.S_AXI_BREADY = 1'b0;
  endtask

  // Driver: full read transaction; lat = edges from AR handshake to RVALID
  task automatic axi_read(input logic [31:0] a, output logic [31:0] d,
                          output logic [1:0] resp, output int lat);
    int n;
    bus.S_AXI_ARADDR  = a;
    bus.S_AXI_ARVALID = 1'b1;
    bus.S_AXI_RREADY  = 1'b0;
    n = 0;
    while (!bus.S_AXI_ARREADY && n < 50) begin
      tick();
      n++;
    end
    tick();
    bus.S_AXI_ARVALID = 1'b0;
    lat = 0;
    while (!bus.S_AXI_RVALID && lat < 50) begin
      tick();
      lat++;
    end
    d    = bus.S_AXI_RDATA;
    resp = bus.S_AXI_RRESP;
    bus.S_AXI_RREADY = 1'b1;
    tick();
    bus.S_AXI_RREADY = 1'b0;
  endtask

  task automatic test_reset();
    bus.S_AXI_ARADDR = '0; bus.S_AXI_ARVALID = 1'b0; bus.S_AXI_RREADY = 1'b0;
    bus.S_AXI_AWADDR = '0; bus.S_AXI_AWVALID = 1'b0;
    bus.S_AXI_WDATA  = '0; bus.S_AXI_WSTRB   = '0; bus.S_AXI_WVALID = 1'b0;
    bus.S_AXI_BREADY = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_vec++; if (bus.S_AXI_ARREADY !== 1'b1) begin n_err++; $display("FAIL reset_arready: got %b want 1", bus.S_AXI_ARREADY); end
    n_vec++; if (bus.S_AXI_AWREADY !== 1'b1) begin n_err++; $display("FAIL reset_awready: got %b want 1", bus.S_AXI_AWREADY); end
    n_vec++; if (bus.S_AXI_WREADY !== 1'b1) begin n_err++; $display("FAIL reset_wready: got %b want 1", bus.S_AXI_WREADY); end
    n_vec++; if (bus.S_AXI_RVALID !== 1'b0) begin n_err++; $display("FAIL reset_rvalid: got %b want 0", bus.S_AXI_RVALID); end
    n_vec++; if (bus.S_AXI_BVALID !== 1'b0) begin n_err++; $display("FAIL reset_bvalid: got %b want 0", bus.S_AXI_BVALID); end
    n_vec++; if (bus.S_AXI_RDATA !== 32'h0) begin n_err++; $display("FAIL reset_rdata: got %h want 0", bus.S_AXI_RDATA); end
    n_vec++; if (bus.S_AXI_RRESP !== 2'b00 || bus.S_AXI_BRESP !== 2'b00) begin n_err++; $display("FAIL reset_resp: got r=%b b=%b want 00", bus.S_AXI_RRESP, bus.S_AXI_BRESP); end
    n_vec++; if (dbg_rd_state !== ST_IDLE || dbg_wr_state !== ST_IDLE) begin n_err++; $display("FAIL reset_states: got rd=%0d wr=%0d want 0", dbg_rd_state, dbg_wr_state); end
  endtask

  task automatic test_write_read_basic();
    logic [1:0]  resp;
    logic [31:0] d;
    int          lat;
    drive_aw_w(32'h8000_0010, 32'hDEAD_BEEF, 4'hF);
    wait_b(resp, lat);
    n_vec++; if (resp !== 2'b00) begin n_err++; $display("FAIL basic_bresp: got %b want 00", resp); end
    n_vec++; if (lat !== 1) begin n_err++; $display("FAIL basic_b_latency: got %0d want 1", lat); end
    axi_read(32'h8000_0010, d, resp, lat);
    n_vec++; if (d !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL basic_rdata: got %h want deadbeef", d); end
    n_vec++; if (resp !== 2'b00) begin n_err++; $display("FAIL basic_rresp: got %b want 00", resp); end
    n_vec++; if (lat !== 1) begin n_err++; $display("FAIL basic_r_latency: got %0d want 1", lat); end
  endtask

  task automatic test_w_before_aw();
    logic [1:0]  resp;
    logic [31:0] d;
    int          lat;
    bus.S_AXI_WDATA  = 32'h1122_3344;
    bus.S_AXI_WSTRB  = 4'b0101;
    bus.S_AXI_WVALID = 1'b1;
    tick();
    bus.S_AXI_WVALID = 1'b0;
    n_vec++; if (bus.S_AXI_WREADY !== 1'b0) begin n_err++; $display("FAIL wfirst_wready: got %b want 0", bus.S_AXI_WREADY); end
    n_vec++; if (bus.S_AXI_AWREADY !== 1'b1) begin n_err++; $display("FAIL wfirst_awready: got %b want 1", bus.S_AXI_AWREADY); end
    tick();
    tick();
    n_vec++; if (bus.S_AXI_BVALID !== 1'b0 || dbg_wr_state !== ST_IDLE) begin n_err++; $display("FAIL wfirst_idle: got bvalid=%b wr=%0d want 0 0", bus.S_AXI_BVALID, dbg_wr_state); end
    bus.S_AXI_AWADDR  = 32'h8000_0010;
    bus.S_AXI_AWVALID = 1'b1;
    tick();
    bus.S_AXI_AWVALID = 1'b0;
    wait_b(resp, lat);
    n_vec++; if (resp !== 2'b00) begin n_err++; $display("FAIL wfirst_bresp: got %b want 00", resp); end
    n_vec++; if (lat !== 1) begin n_err++; $display("FAIL wfirst_b_latency: got %0d want 1", lat); end
    axi_read(32'h8000_0010, d, resp, lat);
    n_vec++; if (d !== 32'hDE22_BE44) begin n_err++; $display("FAIL wfirst_merge: got %h want de22be44", d); end
  endtask

  task automatic test_out_of_range();
    logic [1:0]  resp;
    logic [31:0] d;
    int          lat;
    drive_aw_w(32'h8000_0000, 32'h0123_4567, 4'hF);
    wait_b(resp, lat);
    n_vec++; if (resp !== 2'b00) begin n_err++; $display("FAIL oor_word0_bresp: got %b want 00", resp); end
    drive_aw_w(32'h8000_4000, 32'hCAFE_F00D, 4'hF);
    wait_b(resp, lat);
    n_vec++; if (resp !== 2'b10) begin n_err++; $display("FAIL oor_write_bresp: got %b want 10", resp); end
    n_vec++; if (lat !== 1) begin n_err++; $display("FAIL oor_write_latency: got %0d want 1", lat); end
    axi_read(32'h8000_0000, d, resp, lat);
    n_vec++; if (d !== 32'h0123_4567) begin n_err++; $display("FAIL oor_word0_kept: got %h want 01234567", d); end
    axi_read(32'h7FFF_FFFC, d, resp, lat);
    n_vec++; if (resp !== 2'b10) begin n_err++; $display("FAIL oor_read_rresp: got %b want 10", resp); end
    n_vec++; if (d !== 32'h0) begin n_err++; $display("FAIL oor_read_rdata: got %h want 0", d); end
    axi_read(32'h8000_4000, d, resp, lat);
    n_vec++; if (resp !== 2'b10 || d !== 32'h0) begin n_err++; $display("FAIL oor_read_top: got resp=%b data=%h want 10 0", resp, d); end
    drive_aw_w(32'h8000_3FFC, 32'hA5A5_5A5A, 4'hF);
    wait_b(resp, lat);
    n_vec++; if (resp !== 2'b00) begin n_err++; $display("FAIL last_word_bresp: got %b want 00", resp); end
    axi_read(32'h8000_3FFF, d, resp, lat);
    n_vec++; if (resp !== 2'b00 || d !== 32'hA5A5_5A5A) begin n_err++; $display("FAIL last_word_read: got resp=%b data=%h want 00 a5a55a5a", resp, d); end
  endtask

  task automatic test_rready_stall();
    logic [31:0] held;
    bus.S_AXI_ARADDR  = 32'h8000_0010;
    bus.S_AXI_ARVALID = 1'b1;
    bus.S_AXI_RREADY  = 1'b0;
    tick();
    n_vec++; if (bus.S_AXI_ARREADY !== 1'b0 || bus.S_AXI_RVALID !== 1'b0) begin n_err++; $display("FAIL stall_after_ar: got arready=%b rvalid=%b want 0 0", bus.S_AXI_ARREADY, bus.S_AXI_RVALID); end
    tick();
    n_vec++; if (bus.S_AXI_RVALID !== 1'b1) begin n_err++; $display("FAIL stall_rvalid: got %b want 1", bus.S_AXI_RVALID); end
    held = 32'hDE22_BE44;
    for (int c = 0; c < 5; c++) begin
      tick();
      n_vec++; if (bus.S_AXI_RVALID !== 1'b1) begin n_err++; $display("FAIL stall_rvalid_hold[%0d]: got %b want 1", c, bus.S_AXI_RVALID); end
      n_vec++; if (bus.S_AXI_RDATA !== held || bus.S_AXI_RRESP !== 2'b00) begin n_err++; $display("FAIL stall_payload[%0d]: got %h/%b want %h/00", c, bus.S_AXI_RDATA, bus.S_AXI_RRESP, held); end
      n_vec++; if (bus.S_AXI_ARREADY !== 1'b0) begin n_err++; $display("FAIL stall_arready[%0d]: got %b want 0", c, bus.S_AXI_ARREADY); end
    end
    bus.S_AXI_ARVALID = 1'b0;
    bus.S_AXI_RREADY  = 1'b1;
    tick();
    bus.S_AXI_RREADY  = 1'b0;
    n_vec++; if (bus.S_AXI_RVALID !== 1'b0 || bus.S_AXI_ARREADY !== 1'b1) begin n_err++; $display("FAIL stall_release: got rvalid=%b arready=%b want 0 1", bus.S_AXI_RVALID, bus.S_AXI_ARREADY); end
  endtask

  task automatic test_back_to_back();
    int hs [3];
    int n_hs;
    hs   = '{-100, -100, -100};
    n_hs = 0;
    bus.S_AXI_ARADDR  = 32'h8000_0010;
    bus.S_AXI_ARVALID = 1'b1;
    bus.S_AXI_RREADY  = 1'b1;
    for (int c = 0; c < 9; c++) begin
      if (bus.S_AXI_ARREADY && n_hs < 3) begin
        hs[n_hs] = c;
        n_hs++;
      end
      if (bus.S_AXI_RVALID) begin
        n_vec++; if (bus.S_AXI_RDATA !== 32'hDE22_BE44) begin n_err++; $display("FAIL b2b_rdata[%0d]: got %h want de22be44", c, bus.S_AXI_RDATA); end
      end
      tick();
    end
    bus.S_AXI_ARVALID = 1'b0;
    bus.S_AXI_RREADY  = 1'b0;
    n_vec++; if (hs[0] !== 0) begin n_err++; $display("FAIL b2b_first_ar: got %0d want 0", hs[0]); end
    n_vec++; if (hs[1] - hs[0] !== 3) begin n_err++; $display("FAIL b2b_spacing1: got %0d want 3", hs[1] - hs[0]); end
    n_vec++; if (hs[2] - hs[1] !== 3) begin n_err++; $display("FAIL b2b_spacing2: got %0d want 3", hs[2] - hs[1]); end
    n_vec++; if (dbg_rd_state !== ST_IDLE) begin n_err++; $display("FAIL b2b_end_idle: got %0d want 0", dbg_rd_state); end
  endtask

  task automatic test_reset_mid_write();
    logic [1:0]  resp;
    logic [31:0] d;
    int          lat;
    drive_aw_w(32'h8000_0010, 32'h5555_AAAA, 4'hF);
    n_vec++; if (dbg_wr_state !== ST_WAIT) begin n_err++; $display("FAIL rstmid_in_wait: got %0d want 1", dbg_wr_state); end
    rst_n = 1'b0;
    #1;
    n_vec++; if (dbg_wr_state !== ST_IDLE || bus.S_AXI_BVALID !== 1'b0) begin n_err++; $display("FAIL rstmid_abort: got wr=%0d bvalid=%b want 0 0", dbg_wr_state, bus.S_AXI_BVALID); end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    tick();
    n_vec++; if (bus.S_AXI_BVALID !== 1'b0) begin n_err++; $display("FAIL rstmid_bvalid: got %b want 0", bus.S_AXI_BVALID); end
    n_vec++; if (dbg_rd_state !== ST_IDLE || dbg_wr_state !== ST_IDLE) begin n_err++; $display("FAIL rstmid_idle: got rd=%0d wr=%0d want 0 0", dbg_rd_state, dbg_wr_state); end
    n_vec++; if (bus.S_AXI_AWREADY !== 1'b1 || bus.S_AXI_WREADY !== 1'b1) begin n_err++; $display("FAIL rstmid_ready: got aw=%b w=%b want 1 1", bus.S_AXI_AWREADY, bus.S_AXI_WREADY); end
    axi_read(32'h8000_0010, d, resp, lat);
    n_vec++; if (d !== 32'hDE22_BE44 || resp !== 2'b00) begin n_err++; $display("FAIL rstmid_word_kept: got %h/%b want de22be44/00", d, resp); end
  endtask

  // Test sequence and final report
  initial begin
    n_vec = 0;
    n_err = 0;
    test_reset();
    test_write_read_basic();
    test_w_before_aw();
    test_out_of_range();
    test_rready_stall();
    test_back_to_back();
    test_reset_mid_write();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
